// File: rtl/ntt_conf_sequencer.sv
// Sequencer for the 4-bit conf bus of the 512-point NTT top_stage.
// It walks a fixed phase table per mode, advancing on done_flag rising edges or after a settle count.
module ntt_conf_sequencer #(
    parameter int unsigned SETTLE  = 11,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       abort,
    input  logic [1:0] done_flag,
    output logic [3:0] conf,
    output logic       busy,
    output logic [2:0] step,
    output logic       done,
    output logic       err
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT0,
        S_WAIT1,
        S_SETTLE,
        S_DONE,
        S_ERR
    } state_t;

    typedef struct packed {
        state_t     kind;
        logic [3:0] conf;
        logic       last;
    } phase_t;

    // Phase table: {mode, step} -> kind of wait, conf code, last-step marker
    function automatic phase_t phase_lookup(input logic [1:0] m, input logic [2:0] s);
        phase_t p;
        p = '{kind: S_IDLE, conf: 4'd0, last: 1'b1};
        case ({m, s})
            5'b00_000: p = '{kind: S_WAIT0,  conf: 4'd1, last: 1'b0};
            5'b00_001: p = '{kind: S_SETTLE, conf: 4'd3, last: 1'b0};
            5'b00_010: p = '{kind: S_WAIT1,  conf: 4'd2, last: 1'b1};
            5'b01_000: p = '{kind: S_WAIT0,  conf: 4'd5, last: 1'b0};
            5'b01_001: p = '{kind: S_WAIT1,  conf: 4'd6, last: 1'b1};
            5'b10_000: p = '{kind: S_WAIT0,  conf: 4'd1, last: 1'b0};
            5'b10_001: p = '{kind: S_SETTLE, conf: 4'd3, last: 1'b0};
            5'b10_010: p = '{kind: S_WAIT1,  conf: 4'd2, last: 1'b0};
            5'b10_011: p = '{kind: S_SETTLE, conf: 4'd4, last: 1'b0};
            5'b10_100: p = '{kind: S_WAIT0,  conf: 4'd5, last: 1'b0};
            5'b10_101: p = '{kind: S_WAIT1,  conf: 4'd6, last: 1'b1};
            default:   p = '{kind: S_IDLE,   conf: 4'd0, last: 1'b1};
        endcase
        return p;
    endfunction

    state_t           state;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       df_q;
    logic             last_q;

    logic [1:0] rise;
    logic       can_start;
    logic       in_wait;
    logic       advance;
    logic [1:0] load_mode;
    logic [2:0] load_idx;
    phase_t     ent;

    assign rise      = done_flag & ~df_q;
    assign can_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign in_wait   = (state == S_WAIT0) || (state == S_WAIT1);
    assign advance   = ((state == S_WAIT0) && rise[0])
                    || ((state == S_WAIT1) && rise[1])
                    || ((state == S_SETTLE) && (cnt >= SET_LAST));

    // One table lookup serves both the first step of a new run and the next step of the current run
    assign load_mode = can_start ? mode : mode_q;
    assign load_idx  = can_start ? 3'd0 : step + 3'd1;
    assign ent       = phase_lookup(load_mode, load_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            mode_q <= 2'd0;
            cnt    <= '0;
            df_q   <= 2'b00;
            last_q <= 1'b0;
            conf   <= 4'd0;
            busy   <= 1'b0;
            step   <= 3'd0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            df_q <= done_flag;
            done <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                cnt   <= '0;
                conf  <= 4'd0;
                busy  <= 1'b0;
                step  <= 3'd0;
                err   <= 1'b0;
            end else if (can_start) begin
                cnt  <= '0;
                step <= 3'd0;
                if (mode == 2'd3) begin
                    state <= S_ERR;
                    conf  <= 4'd0;
                    busy  <= 1'b0;
                    err   <= 1'b1;
                end else begin
                    mode_q <= mode;
                    state  <= ent.kind;
                    conf   <= ent.conf;
                    last_q <= ent.last;
                    busy   <= 1'b1;
                    err    <= 1'b0;
                end
            end else if (advance) begin
                cnt <= '0;
                if (last_q) begin
                    state <= S_DONE;
                    conf  <= 4'd0;
                    busy  <= 1'b0;
                    step  <= 3'd0;
                    done  <= 1'b1;
                end else begin
                    state  <= ent.kind;
                    conf   <= ent.conf;
                    last_q <= ent.last;
                    step   <= load_idx;
                end
            end else if (in_wait && (cnt >= TO_LAST)) begin
                // A rise in this same cycle was already taken as success above
                state <= S_ERR;
                cnt   <= '0;
                conf  <= 4'd0;
                busy  <= 1'b0;
                step  <= 3'd0;
                err   <= 1'b1;
            end else if (in_wait || state == S_SETTLE) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (state == S_DONE) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ntt_conf_sequencer.sv
// Directed bench for ntt_conf_sequencer: phase tables, settle length, timeouts, abort and reset.
module tb_ntt_conf_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       abort;
    logic [1:0] done_flag;
    logic [3:0] conf;
    logic       busy;
    logic [2:0] step;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ntt_conf_sequencer #(.SETTLE(11), .TIMEOUT(1024), .CNT_W(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .done_flag (done_flag),
        .conf      (conf),
        .busy      (busy),
        .step      (step),
        .done      (done),
        .err       (err)
    );

    // Inputs change and outputs are sampled at falling edges
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_flag(input logic b);
        done_flag = b ? 2'b10 : 2'b01;
        @(negedge clk);
        done_flag = 2'b00;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; done_flag = 2'b00;
        cyc(2);
        checks++;
        if ({conf, busy, step, done, err} !== {4'd0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", {conf, busy, step, done, err}, 10'h0);
        end
        rst = 1'b1;
        cyc(2);
        checks++;
        if ({conf, busy, done, err} !== 7'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0", {conf, busy, done, err});
        end
    endtask

    task automatic test_mode0();
        go(2'd0);
        checks++;
        if ({conf, busy, step} !== {4'd1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL m0_first: got %h want %h", {conf, busy, step}, {4'd1, 1'b1, 3'd0});
        end
        for (int i = 1; i < 48; i++) begin
            cyc(1);
            checks++;
            if (conf !== 4'd1) begin
                errors++;
                $display("FAIL m0_hold1 cyc %0d: got %0d want 1", i, conf);
            end
        end
        pulse_flag(1'b0);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if ({conf, step} !== {4'd3, 3'd1}) begin
                errors++;
                $display("FAIL m0_settle cyc %0d: got %h want %h", i, {conf, step}, {4'd3, 3'd1});
            end
            cyc(1);
        end
        checks++;
        if ({conf, step, busy} !== {4'd2, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL m0_after_settle: got %h want %h", {conf, step, busy}, {4'd2, 3'd2, 1'b1});
        end
        for (int i = 1; i < 200; i++) begin
            cyc(1);
            checks++;
            if ({conf, done} !== {4'd2, 1'b0}) begin
                errors++;
                $display("FAIL m0_hold2 cyc %0d: got %h want %h", i, {conf, done}, {4'd2, 1'b0});
            end
        end
        pulse_flag(1'b1);
        checks++;
        if ({done, conf, busy, step, err} !== {1'b1, 4'd0, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL m0_done: got %h want %h", {done, conf, busy, step, err}, {1'b1, 9'd0});
        end
        cyc(1);
        checks++;
        if ({done, conf, busy} !== 6'd0) begin
            errors++;
            $display("FAIL m0_done_one_cycle: got %h want 0", {done, conf, busy});
        end
    endtask

    task automatic test_mode2();
        go(2'd2);
        checks++;
        if ({conf, step} !== {4'd1, 3'd0}) begin
            errors++;
            $display("FAIL m2_s0: got %h want %h", {conf, step}, {4'd1, 3'd0});
        end
        cyc(5);
        pulse_flag(1'b0);
        checks++;
        if ({conf, step} !== {4'd3, 3'd1}) begin
            errors++;
            $display("FAIL m2_s1: got %h want %h", {conf, step}, {4'd3, 3'd1});
        end
        cyc(10);
        checks++;
        if (conf !== 4'd3) begin
            errors++;
            $display("FAIL m2_s1_end: got %0d want 3", conf);
        end
        cyc(1);
        checks++;
        if ({conf, step} !== {4'd2, 3'd2}) begin
            errors++;
            $display("FAIL m2_s2: got %h want %h", {conf, step}, {4'd2, 3'd2});
        end
        cyc(3);
        pulse_flag(1'b1);
        checks++;
        if ({conf, step} !== {4'd4, 3'd3}) begin
            errors++;
            $display("FAIL m2_s3: got %h want %h", {conf, step}, {4'd4, 3'd3});
        end
        cyc(10);
        checks++;
        if (conf !== 4'd4) begin
            errors++;
            $display("FAIL m2_s3_end: got %0d want 4", conf);
        end
        cyc(1);
        checks++;
        if ({conf, step} !== {4'd5, 3'd4}) begin
            errors++;
            $display("FAIL m2_s4: got %h want %h", {conf, step}, {4'd5, 3'd4});
        end
        cyc(2);
        pulse_flag(1'b0);
        checks++;
        if ({conf, step, done} !== {4'd6, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL m2_s5: got %h want %h", {conf, step, done}, {4'd6, 3'd5, 1'b0});
        end
        cyc(2);
        pulse_flag(1'b1);
        checks++;
        if ({done, conf, busy, err} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL m2_done: got %h want %h", {done, conf, busy, err}, {1'b1, 6'd0});
        end
        cyc(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL m2_single_done: got %b want 0", done);
        end
    endtask

    task automatic test_stale_timeout();
        done_flag = 2'b01;
        cyc(3);
        go(2'd1);
        checks++;
        if ({conf, step, busy} !== {4'd5, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL m1_start: got %h want %h", {conf, step, busy}, {4'd5, 3'd0, 1'b1});
        end
        cyc(1023);
        checks++;
        if ({conf, err} !== {4'd5, 1'b0}) begin
            errors++;
            $display("FAIL m1_stale_no_advance: got %h want %h", {conf, err}, {4'd5, 1'b0});
        end
        cyc(1);
        checks++;
        if ({err, conf, busy, step} !== {1'b1, 4'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL m1_timeout: got %h want %h", {err, conf, busy, step}, {1'b1, 8'd0});
        end
        done_flag = 2'b00;
        cyc(5);
        checks++;
        if ({err, conf} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL err_sticky: got %h want %h", {err, conf}, {1'b1, 4'd0});
        end
    endtask

    task automatic test_mode3_and_busy_start();
        do_abort();
        checks++;
        if ({err, conf, busy} !== 6'd0) begin
            errors++;
            $display("FAIL abort_clears_err: got %h want 0", {err, conf, busy});
        end
        go(2'd3);
        checks++;
        if ({err, conf, busy} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL m3_err: got %h want %h", {err, conf, busy}, {1'b1, 5'd0});
        end
        cyc(3);
        checks++;
        if ({err, conf} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL m3_hold: got %h want %h", {err, conf}, {1'b1, 4'd0});
        end
        go(2'd0);
        checks++;
        if ({err, conf, step, busy} !== {1'b0, 4'd1, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL m3_restart: got %h want %h", {err, conf, step, busy}, {1'b0, 4'd1, 3'd0, 1'b1});
        end
        go(2'd1);
        checks++;
        if ({conf, step, err} !== {4'd1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL busy_start_ignored: got %h want %h", {conf, step, err}, {4'd1, 3'd0, 1'b0});
        end
        cyc(1);
        pulse_flag(1'b0);
        checks++;
        if ({conf, step} !== {4'd3, 3'd1}) begin
            errors++;
            $display("FAIL mode_latched: got %h want %h", {conf, step}, {4'd3, 3'd1});
        end
        do_abort();
    endtask

    task automatic test_abort_settle();
        go(2'd2);
        cyc(2);
        pulse_flag(1'b0);
        checks++;
        if (conf !== 4'd3) begin
            errors++;
            $display("FAIL ab_in_settle: got %0d want 3", conf);
        end
        cyc(4);
        do_abort();
        checks++;
        if ({conf, busy, step, done, err} !== 10'd0) begin
            errors++;
            $display("FAIL abort_settle: got %h want 0", {conf, busy, step, done, err});
        end
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            checks++;
            if ({done, conf, busy} !== 6'd0) begin
                errors++;
                $display("FAIL abort_quiet cyc %0d: got %h want 0", i, {done, conf, busy});
            end
        end
    endtask

    task automatic test_async_reset();
        go(2'd0);
        pulse_flag(1'b0);
        cyc(11);
        checks++;
        if ({conf, step} !== {4'd2, 3'd2}) begin
            errors++;
            $display("FAIL rst_in_wait1: got %h want %h", {conf, step}, {4'd2, 3'd2});
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({conf, busy, step, done} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", {conf, busy, step, done});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            checks++;
            if ({done, conf, busy, err} !== 7'd0) begin
                errors++;
                $display("FAIL rst_quiet cyc %0d: got %h want 0", i, {done, conf, busy, err});
            end
        end
    endtask

    task automatic test_back_to_back();
        go(2'd1);
        cyc(3);
        pulse_flag(1'b0);
        checks++;
        if ({conf, step} !== {4'd6, 3'd1}) begin
            errors++;
            $display("FAIL b2b_m1_s1: got %h want %h", {conf, step}, {4'd6, 3'd1});
        end
        cyc(3);
        pulse_flag(1'b1);
        checks++;
        if ({done, conf} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL b2b_done: got %h want %h", {done, conf}, {1'b1, 4'd0});
        end
        go(2'd0);
        checks++;
        if ({conf, step, busy, done} !== {4'd1, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_restart: got %h want %h", {conf, step, busy, done}, {4'd1, 3'd0, 1'b1, 1'b0});
        end
        cyc(1023);
        checks++;
        if ({conf, err} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL coincide_pre: got %h want %h", {conf, err}, {4'd1, 1'b0});
        end
        pulse_flag(1'b0);
        checks++;
        if ({conf, step, err, busy} !== {4'd3, 3'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL coincide_advance: got %h want %h", {conf, step, err, busy}, {4'd3, 3'd1, 1'b0, 1'b1});
        end
        do_abort();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode2();
        test_stale_timeout();
        test_mode3_and_busy_start();
        test_abort_settle();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntt_conf_sequencer.md
Name: ntt_conf_sequencer

Overview:
- Control FSM that drives the 4-bit `conf` bus of `top_stage`, the 512-point mixed-radix NTT over 4 memory banks. It replaces hand-timed `conf` stimulus.
- On a start request it walks a fixed phase table for the chosen operation mode. It advances on completion edges of `top_stage`'s `done_flag`, inserts fixed settle gaps, and guards every wait phase with a timeout.
- Sits between the host/test controller and `top_stage`.

Parameters:
- SETTLE, 11, cycles `conf` is held in a transition phase (conf 3 and conf 4 phases).
- TIMEOUT, 1024, maximum cycles spent in any flag-wait phase before error.
- CNT_W, 11, width of the internal cycle counter; must hold max(SETTLE, TIMEOUT).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle request; honoured only in IDLE, DONE or ERR.
- mode  input  2  0 = forward NTT, 1 = inverse NTT, 2 = forward + pointwise + inverse, 3 = illegal.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- done_flag  input  2  completion flags from `top_stage`; level signals, only rising edges are used.
- conf  output  4  configuration code to `top_stage`.
- busy  output  1  high in any phase state.
- step  output  3  index of the current phase in the table; 0 when idle.
- done  output  1  one-cycle pulse when the sequence completes.
- err  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - conf=0, busy=0, step=0, done=0, err=0, counter=0.
  - State IDLE; done_flag edge registers cleared.
- All outputs are registered. Reset mid-sequence aborts immediately, with no completion pulse.
- Edge detect: `df_q` registers `done_flag` each cycle; `rise = done_flag & ~df_q`. Flags already high when a phase begins do not count.
- States: IDLE, WAIT0, WAIT1, SETTLE, DONE, ERR.
  - The phase table gives, per mode and step: the `conf` code, the kind (WAIT0 = wait rise[0], WAIT1 = wait rise[1], SETTLE = count SETTLE cycles), and whether it is the last step.
- Phase tables:
  - mode 0: s0 conf1 WAIT0; s1 conf3 SETTLE; s2 conf2 WAIT1 (last).
  - mode 1: s0 conf5 WAIT0; s1 conf6 WAIT1 (last).
  - mode 2: s0 conf1 WAIT0; s1 conf3 SETTLE; s2 conf2 WAIT1; s3 conf4 SETTLE; s4 conf5 WAIT0; s5 conf6 WAIT1 (last).
- IDLE/DONE/ERR:
  - On start with mode 0–2: next cycle enters step 0 with that step's `conf`, busy=1, err cleared, counter=0.
  - On start with mode 3: next cycle ERR, err=1, conf=0.
  - `mode` is latched at start; later changes are ignored.
- WAIT phases:
  - The counter increments each cycle.
  - On the required rise bit: next cycle loads the next step (conf updates that cycle, counter=0). If this was the last step, go to DONE instead.
  - If the counter reaches TIMEOUT-1 without the rise: next cycle ERR, err=1, conf=0, busy=0.
  - A rise and a timeout in the same cycle count as success.
- SETTLE: `conf` is held exactly SETTLE cycles (counter 0..SETTLE-1), then the next step is loaded.
- DONE: entered for one cycle with done=1, conf=0, busy=0, step=0; then IDLE. A start during the DONE cycle is accepted, so back-to-back runs are possible.
- ERR: err stays 1 and conf stays 0 until start or abort. abort clears err.
- abort: highest priority after reset. Next cycle IDLE, conf=0, busy=0, done=0; err is cleared.
- start while busy is ignored, with no side effects.
- The counter saturates and never wraps.

Test Plan:
- Reset then mode 0 start at cycle 1; pulse done_flag[0] at cycle 50 and done_flag[1] 200 cycles later -> conf sequence 1 (cycles 2–50), 3 for exactly 11 cycles, 2 until the edge+1, then a done pulse, conf=0.
- Mode 2 full run with flag pulses -> conf sequence 1,3,2,4,5,6,0; step reads 0..5; single done pulse; err=0.
- Mode 1 with done_flag[0] held high from before start -> no advance on the stale level; timeout after 1024 cycles -> err=1, conf=0, busy=0.
- Start with mode 3 -> err=1 next cycle, conf stays 0; subsequent start with mode 0 clears err and conf=1.
- Abort during the mode 2 SETTLE step, and rst pulled low mid-WAIT1 -> conf=0, busy=0, no done pulse; rst response is asynchronous, without waiting for a clk edge.
- Start asserted in the DONE cycle, plus a rise coincident with the timeout cycle -> the new run begins the next cycle; the coincident case advances and does not error.
